// File: rtl/music_pkg.sv
// Shared definitions for the playback sequencer and the track-length comparator:
// state encoding, track count default, time limits and track-step helpers.
package music_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SWITCH = 2'd1,
      ST_PLAY   = 2'd2,
      ST_PAUSE  = 2'd3
   } state_t;

   localparam int         NUM_TRACKS_DEF = 3;
   localparam logic [7:0] SEC_MAX        = 8'd59;
   localparam logic [7:0] MIN_MAX        = 8'd99;

   // Tracks are numbered 1..num and wrap in both directions.
   function automatic logic [1:0] track_step_next(input logic [1:0] cur, input int num);
      logic [1:0] last;
      last = 2'(num);
      return (cur >= last) ? 2'd1 : cur + 2'd1;
   endfunction

   function automatic logic [1:0] track_step_prev(input logic [1:0] cur, input int num);
      logic [1:0] last;
      last = 2'(num);
      return (cur <= 2'd1) ? last : cur - 2'd1;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Seconds prescaler: counts enabled clk cycles 0..TICK_DIV-1 and pulses tick on the wrap.
module tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int         W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

   logic [W-1:0] cnt;

   // A clear in the same cycle suppresses the wrap, so no tick escapes it.
   assign tick = en && !clr && (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/play_sequencer.sv
// Music playback sequencer: key-driven play/pause/stop/track control with an
// elapsed-time counter running only while playing.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | stopped; counters zero; next/prev only retune music_reg
//   ST_SWITCH | one-cycle track (re)start; counters zero, track_start=1
//   ST_PLAY   | playing; prescaler and time counters advance
//   ST_PAUSE  | halted; prescaler and counters hold their values
module play_sequencer
   import music_pkg::*;
#(
   parameter int TICK_DIV   = 50_000_000,
   parameter int NUM_TRACKS = NUM_TRACKS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_play,
   input  logic       key_stop,
   input  logic       key_next,
   input  logic       key_prev,
   input  logic       repeat_one,
   input  logic       track_done,
   output logic [1:0] music_reg,
   output logic [7:0] cnt_sec,
   output logic [7:0] cnt_min,
   output logic       playing,
   output logic       track_start
);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] track_nxt;
   logic       clr_cnt;
   logic       done_q;
   logic       eot;
   logic       sec_tick;

   assign eot = track_done && !done_q && (state == ST_PLAY);

   always_comb begin
      state_nxt = state;
      track_nxt = music_reg;
      if (key_stop) begin
         state_nxt = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (key_next)      track_nxt = track_step_next(music_reg, NUM_TRACKS);
               else if (key_prev) track_nxt = track_step_prev(music_reg, NUM_TRACKS);
               else if (key_play) state_nxt = ST_SWITCH;
            end
            ST_SWITCH: state_nxt = ST_PLAY;
            ST_PLAY: begin
               if (key_next) begin
                  state_nxt = ST_SWITCH;
                  track_nxt = track_step_next(music_reg, NUM_TRACKS);
               end else if (key_prev) begin
                  state_nxt = ST_SWITCH;
                  track_nxt = track_step_prev(music_reg, NUM_TRACKS);
               end else if (eot) begin
                  state_nxt = ST_SWITCH;
                  if (!repeat_one) track_nxt = track_step_next(music_reg, NUM_TRACKS);
               end else if (key_play) begin
                  state_nxt = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (key_next) begin
                  state_nxt = ST_SWITCH;
                  track_nxt = track_step_next(music_reg, NUM_TRACKS);
               end else if (key_prev) begin
                  state_nxt = ST_SWITCH;
                  track_nxt = track_step_prev(music_reg, NUM_TRACKS);
               end else if (key_play) begin
                  state_nxt = ST_PLAY;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
      // Entering SWITCH or IDLE zeroes time, overriding a coincident second tick.
      clr_cnt = (state_nxt == ST_SWITCH) || (state_nxt == ST_IDLE);
   end

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (state == ST_PLAY),
      .clr  (clr_cnt),
      .tick (sec_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         music_reg   <= 2'd1;
         cnt_sec     <= 8'd0;
         cnt_min     <= 8'd0;
         playing     <= 1'b0;
         track_start <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state       <= state_nxt;
         music_reg   <= track_nxt;
         playing     <= (state_nxt == ST_PLAY) || (state_nxt == ST_SWITCH);
         track_start <= (state_nxt == ST_SWITCH);
         done_q      <= track_done;
         if (clr_cnt) begin
            cnt_sec <= 8'd0;
            cnt_min <= 8'd0;
         end else if (sec_tick) begin
            if (cnt_sec == SEC_MAX) begin
               cnt_sec <= 8'd0;
               if (cnt_min != MIN_MAX) cnt_min <= cnt_min + 8'd1;
            end else begin
               cnt_sec <= cnt_sec + 8'd1;
            end
         end
      end
   end

endmodule
